// File: rtl/eq_mac_sequencer_pkg.sv
// Shared types and sizing helpers for the equalizer MAC sequencer.
package eq_mac_sequencer_pkg;

  localparam int unsigned NBANDS_DEF  = 3;
  localparam int unsigned NTAPS_DEF   = 8;
  localparam int unsigned MUL_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Tag carried alongside each operand load through the multiplier latency
  typedef struct packed {
    logic valid;
    logic first;
  } mac_tag_t;

  // Counter/address width that stays legal (>=1) for degenerate sizes
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eq_mac_sequencer_if.sv
// Sequencer control bus: sample strobe in, MAC datapath controls and status out.
interface eq_mac_sequencer_if
  import eq_mac_sequencer_pkg::*;
#(
  parameter int unsigned NBANDS = NBANDS_DEF,
  parameter int unsigned NTAPS  = NTAPS_DEF
);

  localparam int unsigned TW = cnt_w(NTAPS);
  localparam int unsigned BW = cnt_w(NBANDS);
  localparam int unsigned AW = cnt_w(NBANDS * NTAPS);

  logic          sample_valid;
  logic          ovr_clr;
  logic          busy;
  logic          ope_ld;
  logic [TW-1:0] tap_idx;
  logic [AW-1:0] coef_addr;
  logic          acc_clr;
  logic          acc_en;
  logic          band_done;
  logic [BW-1:0] band_id;
  logic          frame_done;
  logic          overrun;

  modport master (
    output sample_valid, ovr_clr,
    input  busy, ope_ld, tap_idx, coef_addr, acc_clr, acc_en,
    input  band_done, band_id, frame_done, overrun
  );

  modport slave (
    input  sample_valid, ovr_clr,
    output busy, ope_ld, tap_idx, coef_addr, acc_clr, acc_en,
    output band_done, band_id, frame_done, overrun
  );

endinterface

// File: rtl/eq_mac_sequencer_mac_valid_pipe.sv
// Delays the {valid,first} tag of each operand load by the multiplier latency so the
// accumulator enable/clear line up with the product.
module eq_mac_sequencer_mac_valid_pipe
  import eq_mac_sequencer_pkg::*;
#(
  parameter int unsigned LAT = MUL_LAT_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  mac_tag_t tag_in,
  output logic     acc_en,
  output logic     acc_clr
);

  mac_tag_t pipe [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LAT); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign acc_en  = pipe[LAT-1].valid;
  assign acc_clr = pipe[LAT-1].first;

endmodule

// File: rtl/eq_mac_sequencer.sv
// Time-multiplexes one MAC datapath over NBANDS FIR bands of NTAPS taps per sample frame.
module eq_mac_sequencer
  import eq_mac_sequencer_pkg::*;
#(
  parameter int unsigned NBANDS  = NBANDS_DEF,
  parameter int unsigned NTAPS   = NTAPS_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input logic               clk,
  input logic               rst,
  eq_mac_sequencer_if.slave bus
);

  localparam int unsigned TW = cnt_w(NTAPS);
  localparam int unsigned BW = cnt_w(NBANDS);
  localparam int unsigned AW = cnt_w(NBANDS * NTAPS);
  localparam int unsigned DW = cnt_w(MUL_LAT);

  localparam logic [TW-1:0] TAP_LAST   = TW'(NTAPS - 1);
  localparam logic [BW-1:0] BAND_LAST  = BW'(NBANDS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MUL_LAT - 1);

  seq_state_e    state, state_nxt;
  logic [TW-1:0] tap, tap_nxt;
  logic [BW-1:0] band, band_nxt;
  logic [DW-1:0] drain, drain_nxt;
  logic [AW-1:0] coef_q, coef_nxt;
  logic          overrun_q, overrun_nxt;
  logic          busy_q, ope_ld_q, band_done_q, frame_done_q;
  logic [BW-1:0] band_id_q;
  logic          last_done;
  mac_tag_t      ld_tag;

  assign last_done = (state == ST_DONE) && (band == BAND_LAST);

  // Next-state, counters and overrun
  always_comb begin
    state_nxt   = state;
    tap_nxt     = tap;
    band_nxt    = band;
    drain_nxt   = drain;
    overrun_nxt = overrun_q;

    unique case (state)
      ST_IDLE: begin
        if (bus.sample_valid) begin
          state_nxt = ST_ISSUE;
          tap_nxt   = '0;
          band_nxt  = '0;
        end
      end
      ST_ISSUE: begin
        if (tap == TAP_LAST) begin
          state_nxt = ST_DRAIN;
          tap_nxt   = '0;
          drain_nxt = '0;
        end else begin
          tap_nxt = tap + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain == DRAIN_LAST) state_nxt = ST_DONE;
        else                     drain_nxt = drain + DW'(1);
      end
      ST_DONE: begin
        tap_nxt = '0;
        if (band != BAND_LAST) begin
          state_nxt = ST_ISSUE;
          band_nxt  = band + BW'(1);
        end else if (bus.sample_valid) begin
          state_nxt = ST_ISSUE;
          band_nxt  = '0;
        end else begin
          state_nxt = ST_IDLE;
          band_nxt  = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A strobe in the final DONE cycle chains a new frame instead of overrunning
    if (bus.ovr_clr) overrun_nxt = 1'b0;
    if (bus.sample_valid && (state != ST_IDLE) && !last_done) overrun_nxt = 1'b1;

    coef_nxt = (state_nxt == ST_ISSUE)
             ? (AW'(band_nxt) * AW'(NTAPS) + AW'(tap_nxt))
             : '0;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      tap          <= '0;
      band         <= '0;
      drain        <= '0;
      coef_q       <= '0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      ope_ld_q     <= 1'b0;
      band_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      band_id_q    <= '0;
    end else begin
      state        <= state_nxt;
      tap          <= tap_nxt;
      band         <= band_nxt;
      drain        <= drain_nxt;
      coef_q       <= coef_nxt;
      overrun_q    <= overrun_nxt;
      busy_q       <= (state_nxt != ST_IDLE);
      ope_ld_q     <= (state_nxt == ST_ISSUE);
      band_done_q  <= (state_nxt == ST_DONE);
      frame_done_q <= (state_nxt == ST_DONE) && (band_nxt == BAND_LAST);
      band_id_q    <= (state_nxt == ST_DONE) ? band_nxt : '0;
    end
  end

  always_comb begin
    ld_tag       = '0;
    ld_tag.valid = ope_ld_q;
    ld_tag.first = ope_ld_q && (tap == '0);
  end

  eq_mac_sequencer_mac_valid_pipe #(
    .LAT (MUL_LAT)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (ld_tag),
    .acc_en  (bus.acc_en),
    .acc_clr (bus.acc_clr)
  );

  assign bus.busy       = busy_q;
  assign bus.ope_ld     = ope_ld_q;
  assign bus.tap_idx    = tap;
  assign bus.coef_addr  = coef_q;
  assign bus.band_done  = band_done_q;
  assign bus.band_id    = band_id_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_eq_mac_sequencer.sv
// Scoreboard bench: default-size sequencer plus a small MUL_LAT=1 instance.
module tb_eq_mac_sequencer;

  localparam int NB = 3, NT = 8, LAT = 2;
  localparam int FRAME = NB * (NT + LAT + 1);
  localparam int NB6 = 2, NT6 = 4, LAT6 = 1;
  localparam int FRAME6 = NB6 * (NT6 + LAT6 + 1);

  typedef struct { int cyc; int a; int b; } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   busy_until = -1;
  int   first_start = -1;
  logic ov_exp = 1'b0;
  int   b_fd_cyc = -1;
  logic b_prev_ld = 1'b0;
  int   n;
  ev_t  q_ld[$];
  ev_t  q_acc[$];
  ev_t  q_band[$];

  eq_mac_sequencer_if #(.NBANDS(NB),  .NTAPS(NT))  bus_a ();
  eq_mac_sequencer_if #(.NBANDS(NB6), .NTAPS(NT6)) bus_b ();

  eq_mac_sequencer #(.NBANDS(NB), .NTAPS(NT), .MUL_LAT(LAT)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );

  eq_mac_sequencer #(.NBANDS(NB6), .NTAPS(NT6), .MUL_LAT(LAT6)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input int s);
    for (int b = 0; b < NB; b++) begin
      int base;
      base = s + 1 + b * (NT + LAT + 1);
      for (int t = 0; t < NT; t++) begin
        q_ld.push_back(ev_t'{base + t, b * NT + t, t});
        q_acc.push_back(ev_t'{base + t + LAT, int'(t == 0), 0});
      end
      q_band.push_back(ev_t'{base + NT + LAT, b, int'(b == NB - 1)});
    end
  endtask

  // One cycle of stimulus; the expected-result model is updated as it is driven
  task automatic drive(input logic sv, input logic clr, input logic svb);
    @(negedge clk);
    #1;
    bus_a.sample_valid = sv;
    bus_a.ovr_clr      = clr;
    bus_b.sample_valid = svb;
    bus_b.ovr_clr      = 1'b0;
    if (svb) b_fd_cyc = cyc + FRAME6;
    if (sv && cyc >= busy_until) begin
      if (cyc > busy_until) first_start = cyc;
      busy_until = cyc + FRAME;
      push_frame(cyc);
      if (clr) ov_exp = 1'b0;
    end else if (sv) begin
      ov_exp = 1'b1;
    end else if (clr) begin
      ov_exp = 1'b0;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a"}, 32'({bus_a.busy, bus_a.ope_ld, bus_a.tap_idx, bus_a.coef_addr,
                            bus_a.acc_clr, bus_a.acc_en, bus_a.band_done, bus_a.band_id,
                            bus_a.frame_done, bus_a.overrun}), 0);
    check({tag, "_b"}, 32'({bus_b.busy, bus_b.ope_ld, bus_b.tap_idx, bus_b.coef_addr,
                            bus_b.acc_clr, bus_b.acc_en, bus_b.band_done, bus_b.band_id,
                            bus_b.frame_done, bus_b.overrun}), 0);
  endtask

  // Default-size instance: pop expected events as the DUT produces them
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      check("busy", 32'(bus_a.busy), int'(cyc > first_start && cyc <= busy_until));
      check("overrun", 32'(bus_a.overrun), int'(ov_exp));

      if (q_ld.size() > 0 && q_ld[0].cyc < cyc) begin
        check("ope_ld_missing", 32'(cyc), q_ld[0].cyc);
        q_ld.delete(0);
      end
      if (bus_a.ope_ld) begin
        if (q_ld.size() == 0) check("ope_ld_unexpected", 32'(bus_a.ope_ld), 0);
        else begin
          e = q_ld.pop_front();
          check("ope_ld_cycle", 32'(cyc), e.cyc);
          check("coef_addr", 32'(bus_a.coef_addr), e.a);
          check("tap_idx", 32'(bus_a.tap_idx), e.b);
        end
      end

      if (q_acc.size() > 0 && q_acc[0].cyc < cyc) begin
        check("acc_en_missing", 32'(cyc), q_acc[0].cyc);
        q_acc.delete(0);
      end
      if (bus_a.acc_en) begin
        if (q_acc.size() == 0) check("acc_en_unexpected", 32'(bus_a.acc_en), 0);
        else begin
          e = q_acc.pop_front();
          check("acc_en_cycle", 32'(cyc), e.cyc);
          check("acc_clr", 32'(bus_a.acc_clr), e.a);
        end
      end else begin
        check("acc_clr_without_en", 32'(bus_a.acc_clr), 0);
      end

      if (q_band.size() > 0 && q_band[0].cyc < cyc) begin
        check("band_done_missing", 32'(cyc), q_band[0].cyc);
        q_band.delete(0);
      end
      if (bus_a.band_done) begin
        if (q_band.size() == 0) check("band_done_unexpected", 32'(bus_a.band_done), 0);
        else begin
          e = q_band.pop_front();
          check("band_done_cycle", 32'(cyc), e.cyc);
          check("band_id", 32'(bus_a.band_id), e.a);
          check("frame_done", 32'(bus_a.frame_done), e.b);
        end
      end else begin
        check("frame_done_without_band", 32'(bus_a.frame_done), 0);
      end
    end
  end

  // Small instance: acc_en trails ope_ld by one cycle, frame ends FRAME6 after strobe
  always @(negedge clk) begin
    if (rst) begin
      b_prev_ld = 1'b0;
    end else begin
      check("b_acc_en", 32'(bus_b.acc_en), int'(b_prev_ld));
      check("b_frame_done", 32'(bus_b.frame_done), int'(cyc == b_fd_cyc));
      b_prev_ld = bus_b.ope_ld;
    end
  end

  initial begin
    bus_a.sample_valid = 1'b0;
    bus_a.ovr_clr      = 1'b0;
    bus_b.sample_valid = 1'b0;
    bus_b.ovr_clr      = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset("reset");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0);

    // Full frame on both instances
    drive(1'b1, 1'b0, 1'b1);
    repeat (FRAME + 3) drive(1'b0, 1'b0, 1'b0);

    // Overrun set, clear, and set-wins-over-clear
    drive(1'b1, 1'b0, 1'b0);
    repeat (9) drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);

    // Strobe coincident with frame_done chains the next frame
    n = busy_until - cyc - 1;
    repeat (n) drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    repeat (FRAME + 3) drive(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame
    drive(1'b1, 1'b0, 1'b0);
    repeat (14) drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("mid_frame_reset");
    q_ld.delete();
    q_acc.delete();
    q_band.delete();
    busy_until  = -1;
    first_start = -1;
    ov_exp      = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (15) drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    repeat (FRAME + 3) drive(1'b0, 1'b0, 1'b0);

    check("scoreboard_empty", 32'(q_ld.size() + q_acc.size() + q_band.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
